sync_ram_large: RTL and testbench

//  Memory-plus-arithmetic datapath slice of the 8-bit teaching CPU.
//  - 256 x 8-bit single-port synchronous RAM with a shared bidirectional tri-state data bus (program + data store).
//  - Independent combinational 8-bit ALU for the accumulator path: AC op MBR.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/alu_core.sv | 41 ++++
 rtl/sync_ram_large.sv | 52 +++++
 tb/tb_sync_ram_large.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and sizing for the 8-bit teaching CPU datapath.
// The ALU mode encoding here is the controller-visible opcode map.
package cpu_pkg;

  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 8;

  typedef logic [7:0] word_t;

  typedef enum logic [3:0] {
    ALU_PASS_A = 4'b0000,
    ALU_ADD    = 4'b0001,
    ALU_SUB    = 4'b0010,
    ALU_AND    = 4'b0011,
    ALU_OR     = 4'b0100,
    ALU_XOR    = 4'b0101,
    ALU_NOT_A  = 4'b0110,
    ALU_SHL    = 4'b0111,
    ALU_SHR    = 4'b1000,
    ALU_INC    = 4'b1001,
    ALU_ZERO   = 4'b1010,
    ALU_PASS_B = 4'b1011
  } alu_mode_e;

endpackage

// File: rtl/alu_core.sv
// Combinational accumulator ALU: s = a <op> b, unsigned, modulo 2**WIDTH.
// Reserved codes produce zero.
module alu_core
  import cpu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  alu_mode_e          mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   s
);

  logic [WIDTH-1:0] one_s;
  logic [WIDTH-1:0] res_s;

  assign one_s = {{(WIDTH-1){1'b0}}, 1'b1};

  // Operation decode; carry and borrow fall off the top.
  always_comb begin
    res_s = {WIDTH{1'b0}};
    case (mode)
      ALU_PASS_A: res_s = a;
      ALU_ADD:    res_s = a + b;
      ALU_SUB:    res_s = a - b;
      ALU_AND:    res_s = a & b;
      ALU_OR:     res_s = a | b;
      ALU_XOR:    res_s = a ^ b;
      ALU_NOT_A:  res_s = ~a;
      ALU_SHL:    res_s = {a[WIDTH-2:0], 1'b0};
      ALU_SHR:    res_s = {1'b0, a[WIDTH-1:1]};
      ALU_INC:    res_s = a + one_s;
      ALU_ZERO:   res_s = {WIDTH{1'b0}};
      ALU_PASS_B: res_s = b;
      default:    res_s = {WIDTH{1'b0}};
    endcase
  end

  assign s = res_s;

endmodule

// File: rtl/sync_ram_large.sv
// Single-port synchronous RAM on a shared tri-state bus, plus the accumulator ALU.
// One-cycle read latency through rd_q_r; the bus is released whenever we is high.
module sync_ram_large #(
  parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  cs_input,
  input  logic                  we,
  input  logic                  oe,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [3:0]            aluMode,
  output logic [DATA_WIDTH-1:0] s
);

  logic [DATA_WIDTH-1:0] mem_r [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_q_r;
  logic                  drive_s;

  // Write port; reset blocks a write in the same cycle, contents are never cleared.
  always_ff @(posedge clk) begin
    if (!rst && cs_input && we) begin
      mem_r[addr] <= data;
    end
  end

  // Read register: loads on a selected non-write cycle, holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q_r <= {DATA_WIDTH{1'b0}};
    end else if (cs_input && !we) begin
      rd_q_r <= mem_r[addr];
    end
  end

  assign drive_s = cs_input & oe & ~we;
  assign data    = drive_s ? rd_q_r : {DATA_WIDTH{1'bz}};

  alu_core #(
    .WIDTH (DATA_WIDTH)
  ) u_alu (
    .mode (cpu_pkg::alu_mode_e'(aluMode)),
    .a    (a),
    .b    (b),
    .s    (s)
  );

endmodule

// File: tb/tb_sync_ram_large.sv
// Self-checking bench for sync_ram_large: directed RAM/bus sequences, a table of
// ALU vectors, and randomized RAM traffic and ALU operands against a reference model.
module tb_sync_ram_large;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] addr = 8'h00;
  logic       cs_input = 1'b0;
  logic       we = 1'b0;
  logic       oe = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic [3:0] aluMode = 4'h0;
  logic [7:0] s;
  logic [7:0] tb_data = 8'h00;
  logic       tb_drv = 1'b0;
  wire  [7:0] data;

  assign data = tb_drv ? tb_data : 8'hzz;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: memory image (-1 = never written) and read register.
  int m_mem [256];
  int m_rdq = 0;

  sync_ram_large dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .data     (data),
    .cs_input (cs_input),
    .we       (we),
    .oe       (oe),
    .a        (a),
    .b        (b),
    .aluMode  (aluMode),
    .s        (s)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } alu_vec_t;

  // A released bus reads as Z in a 4-state simulator and as 0 in a 2-state one.
  function automatic bit floating(input logic [7:0] v);
    return $isunknown(v) || (v == 8'h00);
  endfunction

  function automatic int alu_ref(input int mode, input int x, input int y);
    case (mode)
      0:  return x;
      1:  return (x + y) % 256;
      2:  return (x - y + 256) % 256;
      3:  return x & y;
      4:  return x | y;
      5:  return x ^ y;
      6:  return 255 - x;
      7:  return (x * 2) % 256;
      8:  return x / 2;
      9:  return (x + 1) % 256;
      11: return y;
      default: return 0;
    endcase
  endfunction

  task automatic cyc(input logic r, input logic c, input logic w, input logic o,
                     input logic [7:0] ad, input logic [7:0] dt);
    @(negedge clk);
    rst = r; cs_input = c; we = w; oe = o; addr = ad; tb_data = dt; tb_drv = w;
    @(posedge clk);
    if (r) m_rdq = 0;
    else if (c && w) m_mem[ad] = int'(dt);
    else if (c) m_rdq = m_mem[ad];
    #1;
  endtask

  task automatic check_val(input string nm, input logic [7:0] exp);
    n_checks++;
    if (data !== exp) begin
      n_errors++;
      $display("FAIL %s: data=%h expected=%h", nm, data, exp);
    end
  endtask

  task automatic check_z(input string nm);
    n_checks++;
    if (!floating(data)) begin
      n_errors++;
      $display("FAIL %s: data=%h expected=released bus", nm, data);
    end
  endtask

  // Model-based bus check for whatever cycle just happened.
  task automatic check_model(input string nm);
    if (we) return;
    if (cs_input && oe) begin
      if (m_rdq >= 0) check_val(nm, 8'(m_rdq));
    end else begin
      check_z(nm);
    end
  endtask

  task automatic check_alu(input string nm, input logic [7:0] exp);
    n_checks++;
    if (s !== exp) begin
      n_errors++;
      $display("FAIL %s: mode=%h a=%h b=%h s=%h expected=%h", nm, aluMode, a, b, s, exp);
    end
  endtask

  alu_vec_t alu_tab [12];
  logic [7:0] prog [34];

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = -1;

    alu_tab[0]  = '{4'b0001, 8'h00, 8'h01, 8'h01};
    alu_tab[1]  = '{4'b0001, 8'hFF, 8'h01, 8'h00};
    alu_tab[2]  = '{4'b0010, 8'h0B, 8'h01, 8'h0A};
    alu_tab[3]  = '{4'b0010, 8'h00, 8'h01, 8'hFF};
    alu_tab[4]  = '{4'b0000, 8'h5A, 8'hC3, 8'h5A};
    alu_tab[5]  = '{4'b0011, 8'hF0, 8'h3C, 8'h30};
    alu_tab[6]  = '{4'b0110, 8'h0F, 8'h00, 8'hF0};
    alu_tab[7]  = '{4'b0111, 8'h81, 8'h00, 8'h02};
    alu_tab[8]  = '{4'b1000, 8'h81, 8'h00, 8'h40};
    alu_tab[9]  = '{4'b1001, 8'hFF, 8'h00, 8'h00};
    alu_tab[10] = '{4'b1011, 8'h12, 8'h34, 8'h34};
    alu_tab[11] = '{4'b1110, 8'h12, 8'h34, 8'h00};

    for (int i = 0; i < 34; i++) prog[i] = 8'((i * 37 + 11) ^ (i << 3));
    prog[0] = 8'h10;
    prog[1] = 8'h1C;
    prog[33] = 8'h01;

    // Reset state: read register cleared, driven onto the bus.
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00);
    check_val("reset_rdq", 8'h00);

    // Two writes, then a one-cycle-latency read.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h10);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h01, 8'h1C);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 8'h00);
    check_val("read_01", 8'h1C);

    // Deselected write ignored; oe or cs low releases the bus.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hAA);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00);
    check_val("cs0_write_ignored", 8'h10);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    check_z("oe0_release");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    check_z("cs0_release");

    // oe and we together: the write lands.
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'h05, 8'h77);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h05, 8'h00);
    check_val("oe_we_write_wins", 8'h77);

    // Reset mid-read, then the same read without reset.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h21, 8'h01);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 8'h21, 8'h00);
    check_val("reset_mid_read", 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h21, 8'h00);
    check_val("read_after_reset", 8'h01);

    // Reset suppresses a same-cycle write.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h30, 8'h33);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h30, 8'h5A);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h30, 8'h00);
    check_val("reset_blocks_write", 8'h33);

    // Program load and readback, plus the last address.
    for (int i = 0; i < 34; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'(i), prog[i]);
    for (int i = 0; i < 34; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'(i), 8'h00);
      check_val($sformatf("prog_%0d", i), prog[i]);
    end
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 8'hC5);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 8'h00);
    check_val("last_byte", 8'hC5);

    // ALU table.
    for (int i = 0; i < 12; i++) begin
      aluMode = alu_tab[i].mode; a = alu_tab[i].a; b = alu_tab[i].b;
      #1;
      check_alu($sformatf("alu_tab_%0d", i), alu_tab[i].exp);
    end

    // Fill remaining addresses so every random read has a known answer.
    for (int i = 34; i < 255; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'(i), 8'($urandom));

    // Randomized RAM traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom_range(0, 2) == 0),
          1'($urandom), 8'($urandom), 8'($urandom));
      check_model($sformatf("rand_ram_%0d", i));
    end

    // Randomized ALU operands over every mode.
    for (int i = 0; i < 200; i++) begin
      aluMode = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
      #1;
      check_alu($sformatf("rand_alu_%0d", i), 8'(alu_ref(int'(aluMode), int'(a), int'(b))));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
